// File: rtl/her_responder_pkg.sv
// Shared descriptor types and widths for the HER receive path.
// Feedback fields mirror the HER fields one-to-one.
package her_responder_pkg;

  localparam int C_MSGID_WIDTH = 10;
  localparam int C_ADDR_WIDTH  = 32;
  localparam int C_SIZE_WIDTH  = 32;

  typedef struct packed {
    logic [C_MSGID_WIDTH-1:0] msgid;
    logic [C_ADDR_WIDTH-1:0]  her_addr;
    logic [C_SIZE_WIDTH-1:0]  her_size;
  } her_descr_t;

  typedef struct packed {
    logic [C_MSGID_WIDTH-1:0] msgid;
    logic [C_ADDR_WIDTH-1:0]  pkt_addr;
    logic [C_SIZE_WIDTH-1:0]  pkt_size;
  } feedback_descr_t;

  function automatic feedback_descr_t to_feedback(her_descr_t d);
    feedback_descr_t f;
    f.msgid    = d.msgid;
    f.pkt_addr = d.her_addr;
    f.pkt_size = d.her_size;
    return f;
  endfunction

endpackage

// File: rtl/her_fifo.sv
// Ingress FIFO for HER descriptors; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate count.
module her_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, rptr_q;
  T            mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // Full blocks push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/her_responder.sv
// Receives HERs, tags them with an in-flight slot for dispatch, and returns
// feedback on completion; idle once end-of-stream is seen and all work drains.
module her_responder
  import her_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_TAGS   = 16,
  parameter int TAG_W      = $clog2(NUM_TAGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            her_valid_i,
  output logic            her_ready_o,
  input  her_descr_t      her_descr_i,
  input  logic            eos_i,
  output logic            task_valid_o,
  input  logic            task_ready_i,
  output her_descr_t      task_descr_o,
  output logic [TAG_W-1:0] task_tag_o,
  input  logic            done_valid_i,
  output logic            done_ready_o,
  input  logic [TAG_W-1:0] done_tag_i,
  output logic            feedback_valid_o,
  input  logic            feedback_ready_i,
  output feedback_descr_t feedback_o,
  output logic            idle_o,
  output logic            err_o,
  output logic [31:0]     pkts_in_o,
  output logic [31:0]     pkts_done_o
);

  logic            fifo_full, fifo_empty;
  her_descr_t      fifo_dout;
  logic            her_fire, task_fire, done_fire, done_hit, fb_fire;
  logic [NUM_TAGS-1:0] busy_q, alloc_mask, free_mask;
  logic [TAG_W-1:0]    alloc_tag;
  logic            any_free;
  feedback_descr_t slot_q [NUM_TAGS];
  feedback_descr_t fb_q;
  logic            fb_valid_q, eos_q, idle_q, err_q;
  logic [31:0]     pkts_in_q, pkts_done_q;

  // Gated by reset so the source sees not-ready while the block is held.
  assign her_ready_o = rst_ni && !fifo_full;
  assign her_fire    = her_valid_i && her_ready_o;

  her_fifo #(.DEPTH(FIFO_DEPTH), .T(her_descr_t)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (her_fire),
    .pop   (task_fire),
    .din   (her_descr_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    alloc_tag = '0;
    any_free  = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_tag = TAG_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  assign task_valid_o = !fifo_empty && any_free;
  assign task_descr_o = fifo_dout;
  assign task_tag_o   = alloc_tag;
  assign task_fire    = task_valid_o && task_ready_i;

  assign done_ready_o = !fb_valid_q || feedback_ready_i;
  assign done_fire    = done_valid_i && done_ready_o;
  assign done_hit     = done_fire && busy_q[done_tag_i];
  assign fb_fire      = fb_valid_q && feedback_ready_i;

  // Alloc is chosen from busy_q, so it never collides with the freed bit.
  assign alloc_mask = task_fire ? (NUM_TAGS'(1) << alloc_tag) : '0;
  assign free_mask  = done_hit ? (NUM_TAGS'(1) << done_tag_i) : '0;

  always_ff @(posedge clk_i) begin
    if (task_fire) slot_q[alloc_tag] <= to_feedback(fifo_dout);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      fb_valid_q  <= 1'b0;
      fb_q        <= '0;
      eos_q       <= 1'b0;
      idle_q      <= 1'b0;
      err_q       <= 1'b0;
      pkts_in_q   <= '0;
      pkts_done_q <= '0;
    end else begin
      busy_q <= (busy_q | alloc_mask) & ~free_mask;
      if (done_hit) begin
        fb_q       <= slot_q[done_tag_i];
        fb_valid_q <= 1'b1;
      end else if (fb_fire) begin
        fb_valid_q <= 1'b0;
      end
      if (done_fire && !busy_q[done_tag_i]) err_q <= 1'b1;
      if (eos_i) eos_q <= 1'b1;
      idle_q <= eos_q && fifo_empty && (busy_q == '0) && !fb_valid_q;
      if (her_fire) pkts_in_q   <= pkts_in_q + 32'd1;
      if (fb_fire)  pkts_done_q <= pkts_done_q + 32'd1;
    end
  end

  assign feedback_valid_o = fb_valid_q;
  assign feedback_o       = fb_q;
  assign idle_o           = idle_q;
  assign err_o            = err_q;
  assign pkts_in_o        = pkts_in_q;
  assign pkts_done_o      = pkts_done_q;

endmodule

// File: tb/tb_her_responder.sv
// Directed-plus-random bench for her_responder; a queue/array reference model
// predicts every output each cycle from the handshake rules.
module tb_her_responder;
  import her_responder_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int NUM_TAGS   = 16;
  localparam int TAG_W      = $clog2(NUM_TAGS);

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic her_valid_i = 1'b0, her_ready_o;
  her_descr_t her_descr_i = '0;
  logic eos_i = 1'b0;
  logic task_valid_o, task_ready_i = 1'b0;
  her_descr_t task_descr_o;
  logic [TAG_W-1:0] task_tag_o;
  logic done_valid_i = 1'b0, done_ready_o;
  logic [TAG_W-1:0] done_tag_i = '0;
  logic feedback_valid_o, feedback_ready_i = 1'b0;
  feedback_descr_t feedback_o;
  logic idle_o, err_o;
  logic [31:0] pkts_in_o, pkts_done_o;

  her_responder #(.FIFO_DEPTH(FIFO_DEPTH), .NUM_TAGS(NUM_TAGS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .her_valid_i(her_valid_i), .her_ready_o(her_ready_o), .her_descr_i(her_descr_i),
    .eos_i(eos_i),
    .task_valid_o(task_valid_o), .task_ready_i(task_ready_i),
    .task_descr_o(task_descr_o), .task_tag_o(task_tag_o),
    .done_valid_i(done_valid_i), .done_ready_o(done_ready_o), .done_tag_i(done_tag_i),
    .feedback_valid_o(feedback_valid_o), .feedback_ready_i(feedback_ready_i),
    .feedback_o(feedback_o),
    .idle_o(idle_o), .err_o(err_o), .pkts_in_o(pkts_in_o), .pkts_done_o(pkts_done_o)
  );

  always #5 clk_i = ~clk_i;

  int compared = 0, mismatched = 0;

  // Reference model state
  her_descr_t      fifo_m[$];
  bit              busy_m [NUM_TAGS];
  feedback_descr_t slot_m [NUM_TAGS];
  feedback_descr_t fb_m;
  bit              fbv_m, err_m, eos_m, idle_m;
  logic [31:0]     in_m, done_m;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo_m.delete();
    for (int i = 0; i < NUM_TAGS; i++) busy_m[i] = 1'b0;
    fbv_m = 0; err_m = 0; eos_m = 0; idle_m = 0; in_m = '0; done_m = '0; fb_m = '0;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NUM_TAGS; i++) if (!busy_m[i]) return i;
    return -1;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < NUM_TAGS; i++) n += int'(busy_m[i]);
    return n;
  endfunction

  function automatic her_descr_t rand_descr();
    her_descr_t d;
    d.msgid    = C_MSGID_WIDTH'($urandom);
    d.her_addr = $urandom;
    d.her_size = C_SIZE_WIDTH'($urandom_range(4096));
    return d;
  endfunction

  // Inputs are driven at the falling edge; this checks outputs just after
  // and advances the model across the next rising edge.
  task automatic step_cycle();
    int ft;
    bit her_rdy_e, task_vld_e, done_rdy_e, hit;
    bit her_f, task_f, done_f, fb_f;
    feedback_descr_t hit_fb;
    #1;
    ft         = lowest_free();
    her_rdy_e  = fifo_m.size() < FIFO_DEPTH;
    task_vld_e = fifo_m.size() > 0 && ft >= 0;
    done_rdy_e = !fbv_m || feedback_ready_i;
    chk("her_ready", 128'(her_ready_o), 128'(her_rdy_e));
    chk("task_valid", 128'(task_valid_o), 128'(task_vld_e));
    chk("done_ready", 128'(done_ready_o), 128'(done_rdy_e));
    chk("fb_valid", 128'(feedback_valid_o), 128'(fbv_m));
    chk("idle", 128'(idle_o), 128'(idle_m));
    chk("err", 128'(err_o), 128'(err_m));
    chk("pkts_in", 128'(pkts_in_o), 128'(in_m));
    chk("pkts_done", 128'(pkts_done_o), 128'(done_m));
    if (fifo_m.size() > 0) chk("task_descr", 128'(task_descr_o), 128'(fifo_m[0]));
    if (ft >= 0) chk("task_tag", 128'(task_tag_o), 128'(ft));
    if (fbv_m) chk("feedback", 128'(feedback_o), 128'(fb_m));

    her_f  = her_valid_i && her_rdy_e;
    task_f = task_vld_e && task_ready_i;
    done_f = done_valid_i && done_rdy_e;
    fb_f   = fbv_m && feedback_ready_i;
    hit    = done_f && busy_m[done_tag_i];
    hit_fb = slot_m[done_tag_i];
    idle_m = eos_m && fifo_m.size() == 0 && busy_count() == 0 && !fbv_m;
    if (task_f) begin
      her_descr_t d = fifo_m.pop_front();
      busy_m[ft] = 1'b1;
      slot_m[ft] = '{msgid: d.msgid, pkt_addr: d.her_addr, pkt_size: d.her_size};
    end
    if (her_f) fifo_m.push_back(her_descr_i);
    if (hit) begin
      busy_m[done_tag_i] = 1'b0;
      fb_m = hit_fb;
      fbv_m = 1'b1;
    end else if (fb_f) fbv_m = 1'b0;
    if (done_f && !hit) err_m = 1'b1;
    if (her_f) in_m++;
    if (fb_f) done_m++;
    if (eos_i) eos_m = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Completions are only issued for tags the model holds busy.
  task automatic rand_inputs(input int p_her, input int p_trdy, input int p_done, input int p_frdy);
    int bq[$];
    her_valid_i      = $urandom_range(99) < p_her;
    her_descr_i      = rand_descr();
    task_ready_i     = $urandom_range(99) < p_trdy;
    feedback_ready_i = $urandom_range(99) < p_frdy;
    for (int i = 0; i < NUM_TAGS; i++) if (busy_m[i]) bq.push_back(i);
    done_valid_i = 1'b0;
    done_tag_i   = TAG_W'($urandom);
    if (bq.size() > 0 && $urandom_range(99) < p_done) begin
      done_valid_i = 1'b1;
      done_tag_i   = TAG_W'(bq[$urandom_range(bq.size() - 1)]);
    end
  endtask

  task automatic quiet();
    her_valid_i = 0; task_ready_i = 0; done_valid_i = 0; feedback_ready_i = 0; eos_i = 0;
  endtask

  task automatic reset_outputs_chk(input string pfx);
    chk({pfx, "_her_ready"}, 128'(her_ready_o), 128'(0));
    chk({pfx, "_task_valid"}, 128'(task_valid_o), 128'(0));
    chk({pfx, "_done_ready"}, 128'(done_ready_o), 128'(1));
    chk({pfx, "_fb_valid"}, 128'(feedback_valid_o), 128'(0));
    chk({pfx, "_idle"}, 128'(idle_o), 128'(0));
    chk({pfx, "_err"}, 128'(err_o), 128'(0));
    chk({pfx, "_pkts_in"}, 128'(pkts_in_o), 128'(0));
    chk({pfx, "_pkts_done"}, 128'(pkts_done_o), 128'(0));
  endtask

  initial begin
    her_descr_t d1;
    model_reset();
    #3;
    reset_outputs_chk("rst");
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;

    // Single HER round trip
    d1 = '{msgid: 10'd3, her_addr: 32'h1C00_0000, her_size: 32'd64};
    her_valid_i = 1; her_descr_i = d1; task_ready_i = 1; feedback_ready_i = 1;
    step_cycle();
    her_valid_i = 0;
    step_cycle();
    done_valid_i = 1; done_tag_i = '0;
    step_cycle();
    done_valid_i = 0;
    #1;
    chk("t1_feedback", 128'(feedback_o), 128'({10'd3, 32'h1C00_0000, 32'd64}));
    step_cycle();
    step_cycle();
    chk("t1_pkts_in", 128'(pkts_in_o), 128'(1));
    chk("t1_pkts_done", 128'(pkts_done_o), 128'(1));

    // Completion for a free tag
    done_valid_i = 1; done_tag_i = TAG_W'(7);
    step_cycle();
    done_valid_i = 0;
    step_cycle();
    chk("t5_err", 128'(err_o), 128'(1));
    chk("t5_no_fb", 128'(feedback_valid_o), 128'(0));
    chk("t5_pkts_done", 128'(pkts_done_o), 128'(1));

    // Fill the FIFO with dispatch stalled
    task_ready_i = 0;
    for (int i = 0; i < 10; i++) begin
      her_valid_i = 1; her_descr_i = rand_descr();
      if (i == 8) chk("t2_full", 128'(her_ready_o), 128'(0));
      step_cycle();
    end
    her_valid_i = 0; task_ready_i = 1;
    for (int i = 0; i < 10; i++) step_cycle();

    // Exhaust all tags, then free tag 5
    for (int i = 0; i < 12; i++) begin
      her_valid_i = 1; her_descr_i = rand_descr();
      step_cycle();
    end
    her_valid_i = 0;
    #1;
    chk("t3_exhausted", 128'(task_valid_o), 128'(0));
    done_valid_i = 1; done_tag_i = TAG_W'(5); feedback_ready_i = 1;
    step_cycle();
    done_valid_i = 0;
    #1;
    chk("t3_tag5", 128'(task_tag_o), 128'(5));
    step_cycle();
    step_cycle();

    // Back-to-back completions against a stalled feedback sink
    task_ready_i = 0; feedback_ready_i = 0;
    done_valid_i = 1; done_tag_i = TAG_W'(5);
    step_cycle();
    done_tag_i = TAG_W'(3);
    step_cycle();
    step_cycle();
    feedback_ready_i = 1;
    step_cycle();
    done_valid_i = 0;
    step_cycle();
    step_cycle();

    // Random traffic, then drain
    for (int i = 0; i < 400; i++) begin
      rand_inputs(40, 70, 40, 70);
      step_cycle();
    end
    for (int i = 0; i < 400 && (fifo_m.size() > 0 || busy_count() > 0 || fbv_m); i++) begin
      rand_inputs(0, 80, 60, 80);
      step_cycle();
    end

    // End of stream with two HERs outstanding
    quiet();
    task_ready_i = 1;
    her_valid_i = 1; her_descr_i = rand_descr(); eos_i = 1;
    step_cycle();
    her_descr_i = rand_descr(); eos_i = 0;
    step_cycle();
    her_valid_i = 0;
    for (int i = 0; i < 200 && !idle_m; i++) begin
      rand_inputs(0, 80, 50, 70);
      step_cycle();
    end
    quiet();
    #1;
    chk("t6_idle", 128'(idle_o), 128'(1));
    step_cycle();

    // Reset asserted mid-stream
    for (int i = 0; i < 12; i++) begin
      rand_inputs(70, 50, 30, 20);
      step_cycle();
    end
    rst_ni = 1'b0;
    #1;
    reset_outputs_chk("midrst");
    model_reset();
    quiet();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_inputs(50, 70, 50, 70);
      step_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
